// File: rtl/javk_fetch.sv
// JAVK instruction fetch: walks the PC over the byte bus, assembles 1-3 byte
// instructions and hands them to execute over valid/ready; execute can redirect.
module javk_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_wait,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_op,
  output logic [15:0] instr_opnd,
  output logic [1:0]  instr_len,
  output logic [15:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc
);

  typedef enum logic [1:0] {OP, OPND1, OPND2, HOLD} state_e;

  state_e      state_q;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  op_q;
  logic [15:0] opnd_q;
  logic [1:0]  len_q, len_d;
  logic [15:0] ipc_q;
  logic        capture;

  // Opcode class in the top two bits sets the instruction length.
  always_comb begin
    len_d = 2'd3;
    case (mem_rdata[7:6])
      2'b00:   len_d = 2'd1;
      2'b01:   len_d = 2'd2;
      default: len_d = 2'd3;
    endcase
  end

  assign pc_d        = pc_q + 16'd1;
  assign mem_rd      = (state_q != HOLD);
  assign mem_addr    = pc_q;
  assign capture     = mem_rd & ~mem_wait;
  assign instr_valid = (state_q == HOLD);
  assign instr_op    = op_q;
  assign instr_opnd  = opnd_q;
  assign instr_len   = len_q;
  assign instr_pc    = ipc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OP;
      pc_q    <= RESET_PC;
      op_q    <= '0;
      opnd_q  <= '0;
      len_q   <= '0;
      ipc_q   <= '0;
    end else if (redirect_valid) begin
      // Wins over capture and stall; any partial instruction is abandoned.
      pc_q    <= redirect_pc;
      state_q <= OP;
    end else begin
      case (state_q)
        OP: if (capture) begin
          op_q    <= mem_rdata;
          ipc_q   <= pc_q;
          opnd_q  <= '0;
          len_q   <= len_d;
          pc_q    <= pc_d;
          state_q <= (len_d == 2'd1) ? HOLD : OPND1;
        end
        OPND1: if (capture) begin
          opnd_q[7:0] <= mem_rdata;
          pc_q        <= pc_d;
          state_q     <= (len_q == 2'd2) ? HOLD : OPND2;
        end
        OPND2: if (capture) begin
          opnd_q[15:8] <= mem_rdata;
          pc_q         <= pc_d;
          state_q      <= HOLD;
        end
        HOLD: if (instr_ready) state_q <= OP;
        default: state_q <= OP;
      endcase
    end
  end

endmodule

// File: tb/tb_javk_fetch.sv
// Directed bench for javk_fetch: byte-array memory model, hand-computed expectations.
module tb_javk_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_wait = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [7:0]  instr_op;
  logic [15:0] instr_opnd;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;

  logic [7:0] mem [0:65535];
  int total = 0;
  int bad = 0;

  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  javk_fetch #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_wait(mem_wait), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_op(instr_op), .instr_opnd(instr_opnd),
    .instr_len(instr_len), .instr_pc(instr_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_wait = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mem[16'h0000] = 8'h05; mem[16'h0001] = 8'h06;
    rst = 1'b1; tick(); tick();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid act=%b exp=0", instr_valid); end
    total++; if (instr_op !== 8'h00) begin bad++; $display("FAIL rst_op act=%h exp=00", instr_op); end
    total++; if (instr_opnd !== 16'h0000 || instr_len !== 2'd0 || instr_pc !== 16'h0000) begin bad++; $display("FAIL rst_fields act=%h/%0d/%h exp=0000/0/0000", instr_opnd, instr_len, instr_pc); end
    total++; if (mem_addr !== 16'h0000 || mem_rd !== 1'b1) begin bad++; $display("FAIL rst_fetch act=%h/%b exp=0000/1", mem_addr, mem_rd); end
    rst = 1'b0;
    tick();
    total++; if (instr_valid !== 1'b1 || instr_op !== 8'h05 || instr_len !== 2'd1) begin bad++; $display("FAIL len1 act=%b/%h/%0d exp=1/05/1", instr_valid, instr_op, instr_len); end
    total++; if (instr_opnd !== 16'h0000 || instr_pc !== 16'h0000 || mem_rd !== 1'b0) begin bad++; $display("FAIL len1_f act=%h/%h/%b exp=0000/0000/0", instr_opnd, instr_pc, mem_rd); end
    tick();
    total++; if (instr_valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h0001) begin bad++; $display("FAIL len1_next act=%b/%b/%h exp=0/1/0001", instr_valid, mem_rd, mem_addr); end
  endtask

  task automatic test_back_to_back();
    // continues from test_reset: 06 at 0001 is fetched right after the handshake
    tick();
    total++; if (instr_valid !== 1'b1 || instr_op !== 8'h06 || instr_pc !== 16'h0001) begin bad++; $display("FAIL b2b act=%b/%h/%h exp=1/06/0001", instr_valid, instr_op, instr_pc); end
  endtask

  task automatic test_len3();
    mem[16'h0000] = 8'h83; mem[16'h0001] = 8'h34; mem[16'h0002] = 8'h12;
    do_reset();
    tick();
    total++; if (instr_valid !== 1'b0 || mem_addr !== 16'h0001) begin bad++; $display("FAIL len3_b1 act=%b/%h exp=0/0001", instr_valid, mem_addr); end
    tick(); tick();
    total++; if (instr_valid !== 1'b1 || instr_op !== 8'h83 || instr_len !== 2'd3) begin bad++; $display("FAIL len3 act=%b/%h/%0d exp=1/83/3", instr_valid, instr_op, instr_len); end
    total++; if (instr_opnd !== 16'h1234 || instr_pc !== 16'h0000 || mem_addr !== 16'h0003) begin bad++; $display("FAIL len3_f act=%h/%h/%h exp=1234/0000/0003", instr_opnd, instr_pc, mem_addr); end
  endtask

  task automatic test_wait();
    mem[16'h0000] = 8'h41; mem[16'h0001] = 8'hAA;
    do_reset();
    tick();
    mem_wait = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (mem_addr !== 16'h0001 || instr_valid !== 1'b0) begin bad++; $display("FAIL wait_hold act=%h/%b exp=0001/0", mem_addr, instr_valid); end
    end
    mem_wait = 1'b0;
    tick();
    total++; if (instr_valid !== 1'b1 || instr_op !== 8'h41 || instr_len !== 2'd2) begin bad++; $display("FAIL wait_res act=%b/%h/%0d exp=1/41/2", instr_valid, instr_op, instr_len); end
    total++; if (instr_opnd !== 16'h00AA || instr_pc !== 16'h0000 || mem_addr !== 16'h0002) begin bad++; $display("FAIL wait_f act=%h/%h/%h exp=00AA/0000/0002", instr_opnd, instr_pc, mem_addr); end
  endtask

  task automatic test_hold();
    mem[16'h0000] = 8'h47; mem[16'h0001] = 8'h99; mem[16'h0002] = 8'h00;
    do_reset();
    instr_ready = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (instr_valid !== 1'b1 || mem_rd !== 1'b0 || instr_op !== 8'h47 || instr_opnd !== 16'h0099 || mem_addr !== 16'h0002) begin bad++; $display("FAIL hold act=%b/%b/%h/%h/%h exp=1/0/47/0099/0002", instr_valid, mem_rd, instr_op, instr_opnd, mem_addr); end
    end
    instr_ready = 1'b1;
    tick();
    total++; if (instr_valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h0002) begin bad++; $display("FAIL hold_rel act=%b/%b/%h exp=0/1/0002", instr_valid, mem_rd, mem_addr); end
  endtask

  task automatic test_redirect();
    mem[16'h0000] = 8'h83; mem[16'h0001] = 8'h34; mem[16'h0002] = 8'h12;
    mem[16'h8000] = 8'h00;
    do_reset();
    tick();
    redirect_valid = 1'b1; redirect_pc = 16'h8000;
    tick();
    redirect_valid = 1'b0;
    total++; if (instr_valid !== 1'b0 || mem_addr !== 16'h8000 || mem_rd !== 1'b1) begin bad++; $display("FAIL redir act=%b/%h/%b exp=0/8000/1", instr_valid, mem_addr, mem_rd); end
    tick();
    total++; if (instr_valid !== 1'b1 || instr_op !== 8'h00 || instr_pc !== 16'h8000 || instr_opnd !== 16'h0000) begin bad++; $display("FAIL redir_ins act=%b/%h/%h/%h exp=1/00/8000/0000", instr_valid, instr_op, instr_pc, instr_opnd); end
    // redirect together with a handshake: consumed, and fetch moves to target
    redirect_valid = 1'b1; redirect_pc = 16'h1234;
    tick();
    total++; if (instr_valid !== 1'b0 || mem_addr !== 16'h1234) begin bad++; $display("FAIL redir_hs act=%b/%h exp=0/1234", instr_valid, mem_addr); end
    // redirect beats mem_wait
    mem_wait = 1'b1; redirect_pc = 16'h4000;
    tick();
    mem_wait = 1'b0; redirect_valid = 1'b0;
    total++; if (mem_addr !== 16'h4000 || instr_valid !== 1'b0) begin bad++; $display("FAIL redir_wait act=%h/%b exp=4000/0", mem_addr, instr_valid); end
  endtask

  task automatic test_wrap();
    mem[16'hFFFF] = 8'h80; mem[16'h0000] = 8'h11; mem[16'h0001] = 8'h22;
    mem[16'h5000] = 8'h00;
    do_reset();
    redirect_pc = 16'h5000; redirect_valid = 1'b1;
    tick();
    // in OP with a capture pending: redirect drops it
    redirect_pc = 16'hFFFF;
    tick();
    redirect_valid = 1'b0;
    total++; if (mem_addr !== 16'hFFFF || instr_valid !== 1'b0 || mem_rd !== 1'b1) begin bad++; $display("FAIL wrap_redir act=%h/%b/%b exp=FFFF/0/1", mem_addr, instr_valid, mem_rd); end
    tick();
    total++; if (mem_addr !== 16'h0000) begin bad++; $display("FAIL wrap_pc act=%h exp=0000", mem_addr); end
    tick(); tick();
    total++; if (instr_valid !== 1'b1 || instr_op !== 8'h80 || instr_len !== 2'd3) begin bad++; $display("FAIL wrap act=%b/%h/%0d exp=1/80/3", instr_valid, instr_op, instr_len); end
    total++; if (instr_opnd !== 16'h2211 || instr_pc !== 16'hFFFF || mem_addr !== 16'h0002) begin bad++; $display("FAIL wrap_f act=%h/%h/%h exp=2211/FFFF/0002", instr_opnd, instr_pc, mem_addr); end
  endtask

  task automatic test_reset_override();
    mem[16'h0000] = 8'h83; mem[16'h0001] = 8'h34; mem[16'h0002] = 8'h12;
    do_reset();
    instr_ready = 1'b0;
    tick(); tick(); tick();
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL ovr_pre act=%b exp=1", instr_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (instr_valid !== 1'b0 || instr_op !== 8'h00 || instr_len !== 2'd0 || mem_addr !== 16'h0000) begin bad++; $display("FAIL ovr act=%b/%h/%0d/%h exp=0/00/0/0000", instr_valid, instr_op, instr_len, mem_addr); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (mem_addr !== 16'h0000 || instr_opnd !== 16'h0000 || instr_pc !== 16'h0000) begin bad++; $display("FAIL ovr_mid act=%h/%h/%h exp=0000/0000/0000", mem_addr, instr_opnd, instr_pc); end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    test_reset();
    test_back_to_back();
    test_len3();
    test_wait();
    test_hold();
    test_redirect();
    test_wrap();
    test_reset_override();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/javk_fetch.md
Name: javk_fetch

Overview:
Instruction fetch unit for the JAVK CPU. It sits directly upstream of the register-file/execute core. It drives the 16-bit address bus during fetch cycles and reads instruction bytes over the 8-bit data path. It assembles each 1–3 byte instruction and presents it to decode/execute with a valid/ready handshake, and it accepts PC redirects from execute on branches and jumps.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
mem_addr  out  16  fetch address (current PC)
mem_rd  out  1  fetch read strobe; high while fetching a byte
mem_rdata  in  8  read data; combinational memory, valid in the same cycle as mem_addr
mem_wait  in  1  memory stall; the byte is not captured while high
instr_valid  out  1  assembled instruction available
instr_ready  in  1  consumer accepts the instruction
instr_op  out  8  opcode byte
instr_opnd  out  16  operands, little-endian; unused bytes are zero
instr_len  out  2  instruction length in bytes (1..3)
instr_pc  out  16  address of the opcode byte
redirect_valid  in  1  load new PC, flush current fetch
redirect_pc  in  16  redirect target

Behaviour:
- Length decode from opcode[7:6]: 00 → 1 byte; 01 → 2 bytes; 10 or 11 → 3 bytes.
- FSM states: OP, OPND1, OPND2, HOLD.
- Reset (rst high at clk rising edge):
  - state=OP, pc=RESET_PC.
  - instr_valid=0, instr_op=0, instr_opnd=0, instr_len=0, instr_pc=0.
  - Reset overrides everything, including a fetch in progress and a pending handshake.
- mem_rd=1 in OP/OPND1/OPND2; mem_rd=0 in HOLD. mem_addr=pc at all times.
- "Capture" = mem_rd & ~mem_wait at the rising edge. On every capture, pc <= pc+1, wrapping 16'hFFFF → 16'h0000.
- OP, on capture:
  - instr_op <= mem_rdata; instr_pc <= pc; instr_opnd <= 0.
  - instr_len <= decoded length.
  - Next state: HOLD for length 1, otherwise OPND1.
- OPND1, on capture: instr_opnd[7:0] <= mem_rdata. Next state: HOLD for length 2, otherwise OPND2.
- OPND2, on capture: instr_opnd[15:8] <= mem_rdata. Next state: HOLD.
- With mem_wait high, the state, pc and captured fields all hold.
- instr_valid is 1 exactly when state==HOLD. Outputs stay stable while valid and not ready.
- Handshake = instr_valid & instr_ready at the rising edge → state <= OP, instr_valid drops the next cycle.
- Latency: valid rises the cycle after the last byte is captured. Throughput without stalls is 1 instruction per len+1 cycles.
- Redirect (redirect_valid high at the rising edge), any state:
  - pc <= redirect_pc, state <= OP, instr_valid <= 0.
  - Partially fetched bytes are discarded.
  - Redirect takes priority over capture and over mem_wait.
  - If a handshake occurs in the same cycle, the instruction counts as consumed; redirect still applies.
- Redirect while in OP with a capture also pending: the capture is dropped; the next fetch is at redirect_pc.
- instr_ready is ignored when not in HOLD.

Test Plan:
- Reset, RESET_PC=16'h0000, memory[0]=8'h05, instr_ready=1 → mem_addr 0 with mem_rd=1; next cycle instr_valid=1, op=05, len=1, opnd=0000, pc=0000; then a fetch at 0001.
- memory[0..2]=8'h83,8'h34,8'h12, instr_ready=1 → after 3 captures: valid, op=83, len=3, opnd=1234, pc=0000; next fetch at 0003.
- Memory[0..1]=8'h41,8'hAA, mem_wait held high 2 cycles during OPND1 → pc holds at 0001. Result is op=41, len=2, opnd=00AA, valid on cycle 5 after reset release.
- Instruction held in HOLD with instr_ready=0 for 4 cycles → outputs stable, mem_rd=0. Raise ready → valid drops next cycle and a fetch at the next pc follows.
- Redirect mid-fetch: in OPND1 of a 3-byte opcode, assert redirect_valid with redirect_pc=16'h8000 → no valid for the partial instruction; the next mem_addr is 8000 with mem_rd=1.
- PC wrap: redirect to 16'hFFFF with memory[FFFF]=8'h80, memory[0000]=8'h11, memory[0001]=8'h22 → op=80, opnd=2211, pc=FFFF; next fetch at 0002.
